// File: rtl/si_tag_pkg.sv
// Shared definitions for the tag time extender: tag field widths,
// the padding word and the packed tag layout {subtime, channel}.
package si_tag_pkg;

    localparam int TAG_W            = 32;
    localparam int ROLL_W           = 32;
    localparam int CHANNEL_BITS_DEF = 6;
    localparam int SUBTIME_BITS_DEF = TAG_W - CHANNEL_BITS_DEF;

    localparam logic [TAG_W-1:0] PAD_TAG = 32'h0;

    typedef struct packed {
        logic [SUBTIME_BITS_DEF-1:0] subtime;
        logic [CHANNEL_BITS_DEF-1:0] channel;
    } si_tag_t;

endpackage

// File: rtl/si_sat_counter.sv
// Saturating event counter: counts inc_i pulses, sticks at all-ones.
// Ports: clk_i, rst_ni (async active-low), inc_i, count_o.
module si_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/si_tag_time_extender.sv
// Turns 32-bit tags + per-packet rollover time into absolute timestamps.
// Ports: s_axis_* tag input, m_axis_* timestamp/channel output,
// out_of_order pulse, cnt_dropped / cnt_out_of_order saturating counters.
module si_tag_time_extender
    import si_tag_pkg::*;
#(
    parameter int CHANNEL_BITS = CHANNEL_BITS_DEF,
    parameter int TIME_WIDTH   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [31:0]             s_axis_tdata,
    input  logic [3:0]              s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic [31:0]             s_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [TIME_WIDTH-1:0]   m_axis_tdata,
    output logic [CHANNEL_BITS-1:0] m_axis_tuser,
    output logic                    out_of_order,
    output logic [31:0]             cnt_dropped,
    output logic [31:0]             cnt_out_of_order
);

    localparam int SUB_W   = TAG_W - CHANNEL_BITS;
    localparam int EPOCH_W = TIME_WIDTH - ROLL_W - SUB_W;

    logic                    m_valid_q;
    logic [TIME_WIDTH-1:0]   m_data_q;
    logic [CHANNEL_BITS-1:0] m_user_q;
    logic                    ooo_q;
    logic [EPOCH_W-1:0]      epoch_q;
    logic [EPOCH_W-1:0]      epoch_d;
    logic [ROLL_W-1:0]       last_roll_q;
    logic [ROLL_W-1:0]       last_roll_d;
    logic [TIME_WIDTH-1:0]   prev_ts_q;
    logic                    prev_valid_q;

    logic                  accept;
    logic                  full_keep;
    logic                  is_pad;
    logic                  kept;
    logic                  dropped;
    logic                  ooo;
    logic [TIME_WIDTH-1:0] ts;
    logic                  unused_tlast;

    // tlast carries no meaning for time extension.
    assign unused_tlast = s_axis_tlast;

    assign s_axis_tready = !m_valid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign full_keep     = (s_axis_tkeep == 4'hF);
    assign is_pad        = (s_axis_tdata == PAD_TAG);
    assign kept          = accept && full_keep && !is_pad;
    assign dropped       = accept && !(full_keep && !is_pad);

    // Padding still carries a valid rollover time, so it advances the epoch;
    // partial beats are untrusted and leave the epoch alone.
    always_comb begin
        epoch_d     = epoch_q;
        last_roll_d = last_roll_q;
        if (accept && full_keep) begin
            last_roll_d = s_axis_tuser;
            if (s_axis_tuser < last_roll_q) begin
                epoch_d = epoch_q + EPOCH_W'(1);
            end
        end
    end

    assign ts  = {epoch_d, s_axis_tuser, s_axis_tdata[TAG_W-1:CHANNEL_BITS]};
    assign ooo = kept && prev_valid_q && (ts < prev_ts_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_user_q     <= '0;
            ooo_q        <= 1'b0;
            epoch_q      <= '0;
            last_roll_q  <= '0;
            prev_ts_q    <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            epoch_q     <= epoch_d;
            last_roll_q <= last_roll_d;
            ooo_q       <= ooo;
            if (kept) begin
                m_valid_q    <= 1'b1;
                m_data_q     <= ts;
                m_user_q     <= s_axis_tdata[CHANNEL_BITS-1:0];
                prev_ts_q    <= ts;
                prev_valid_q <= 1'b1;
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign out_of_order  = ooo_q;

    si_sat_counter #(.WIDTH(32)) u_cnt_dropped (
        .clk_i   (clk),
        .rst_ni  (rst),
        .inc_i   (dropped),
        .count_o (cnt_dropped)
    );

    si_sat_counter #(.WIDTH(32)) u_cnt_ooo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .inc_i   (ooo),
        .count_o (cnt_out_of_order)
    );

endmodule

// File: tb/tb_si_tag_time_extender.sv
// Directed bench for si_tag_time_extender: reset, pass-through, drops,
// epoch rollover, ordering, backpressure and mid-stream reset.
module tb_si_tag_time_extender;
    import si_tag_pkg::*;

    logic        clk;
    logic        rst;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic [31:0] s_tuser;
    logic        m_tvalid;
    logic        m_tready;
    logic [63:0] m_tdata;
    logic [5:0]  m_tuser;
    logic        ooo;
    logic [31:0] cnt_drop;
    logic [31:0] cnt_ooo;

    int n_tests = 0;
    int n_fail  = 0;

    si_tag_time_extender #(.CHANNEL_BITS(6), .TIME_WIDTH(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .s_axis_tdata     (s_tdata),
        .s_axis_tkeep     (s_tkeep),
        .s_axis_tlast     (s_tlast),
        .s_axis_tuser     (s_tuser),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tready    (m_tready),
        .m_axis_tdata     (m_tdata),
        .m_axis_tuser     (m_tuser),
        .out_of_order     (ooo),
        .cnt_dropped      (cnt_drop),
        .cnt_out_of_order (cnt_ooo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int sub, input int ch);
        si_tag_t t;
        t.subtime = 26'(sub);
        t.channel = 6'(ch);
        return t;
    endfunction

    task automatic drive(input logic [31:0] d, input logic [3:0] k,
                         input logic [31:0] u);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tuser  = u;
        s_tlast  = 1'b1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tdata  = 32'h0;
        s_tkeep  = 4'h0;
        s_tlast  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        s_tuser  = 32'h0;
        m_tready = 1'b1;
        step();
        step();
        n_tests++;
        if ({m_tvalid, m_tdata, m_tuser, ooo} !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b d=%h u=%h o=%b want all 0",
                     m_tvalid, m_tdata, m_tuser, ooo);
        end
        n_tests++;
        if ({cnt_drop, cnt_ooo} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h/%h want 0/0", cnt_drop, cnt_ooo);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        m_tready = 1'b1;
        drive(32'h0000_0041, 4'hF, 32'd5);
        n_tests++;
        if (m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: got v=%b want 0", m_tvalid);
        end
        step();
        drive(32'h0000_0082, 4'hF, 32'd5);
        n_tests++;
        if ({m_tvalid, m_tdata, m_tuser} !== {1'b1, (64'd5 << 26) | 64'd1, 6'd1}) begin
            n_fail++;
            $display("FAIL basic_first: got v=%b d=%h u=%h want 1 %h 01",
                     m_tvalid, m_tdata, m_tuser, (64'd5 << 26) | 64'd1);
        end
        step();
        idle();
        n_tests++;
        if ({m_tvalid, m_tdata, m_tuser} !== {1'b1, (64'd5 << 26) | 64'd2, 6'd2}) begin
            n_fail++;
            $display("FAIL basic_second: got v=%b d=%h u=%h want 1 %h 02",
                     m_tvalid, m_tdata, m_tuser, (64'd5 << 26) | 64'd2);
        end
        step();
        n_tests++;
        if ({m_tvalid, cnt_drop} !== {1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL basic_idle: got v=%b drop=%0d want 0 0",
                     m_tvalid, cnt_drop);
        end
    endtask

    task automatic test_drop();
        drive(mk(4, 4), 4'hF, 32'd5);
        step();
        drive(32'h0, 4'hF, 32'd5);
        n_tests++;
        if ({m_tvalid, m_tdata, m_tuser} !== {1'b1, (64'd5 << 26) | 64'd4, 6'd4}) begin
            n_fail++;
            $display("FAIL drop_a: got v=%b d=%h u=%h", m_tvalid, m_tdata, m_tuser);
        end
        step();
        drive(mk(5, 5), 4'h7, 32'd5);
        n_tests++;
        if ({m_tvalid, cnt_drop} !== {1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL drop_pad: got v=%b drop=%0d want 0 1", m_tvalid, cnt_drop);
        end
        step();
        drive(mk(6, 6), 4'hF, 32'd5);
        n_tests++;
        if ({m_tvalid, cnt_drop} !== {1'b0, 32'd2}) begin
            n_fail++;
            $display("FAIL drop_partial: got v=%b drop=%0d want 0 2", m_tvalid, cnt_drop);
        end
        step();
        idle();
        n_tests++;
        if ({m_tvalid, m_tdata, m_tuser} !== {1'b1, (64'd5 << 26) | 64'd6, 6'd6}) begin
            n_fail++;
            $display("FAIL drop_c: got v=%b d=%h u=%h", m_tvalid, m_tdata, m_tuser);
        end
        step();
    endtask

    task automatic test_epoch();
        drive(mk(1, 1), 4'hF, 32'hFFFF_FFF0);
        step();
        drive(mk(1, 1), 4'hF, 32'h0000_0003);
        n_tests++;
        if ({m_tvalid, m_tdata, ooo} !== {1'b1, 6'd0, 32'hFFFF_FFF0, 26'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL epoch_pre: got v=%b d=%h o=%b", m_tvalid, m_tdata, ooo);
        end
        step();
        idle();
        n_tests++;
        if ({m_tvalid, m_tdata, ooo} !== {1'b1, 6'd1, 32'd3, 26'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL epoch_wrap: got v=%b d=%h o=%b want epoch 1",
                     m_tvalid, m_tdata, ooo);
        end
        step();
    endtask

    task automatic test_order();
        drive(mk(100, 0), 4'hF, 32'd3);
        step();
        drive(mk(50, 0), 4'hF, 32'd3);
        n_tests++;
        if ({m_tvalid, m_tdata, ooo} !== {1'b1, 6'd1, 32'd3, 26'd100, 1'b0}) begin
            n_fail++;
            $display("FAIL order_first: got v=%b d=%h o=%b", m_tvalid, m_tdata, ooo);
        end
        step();
        idle();
        n_tests++;
        if ({m_tvalid, m_tdata, ooo, cnt_ooo} !==
            {1'b1, 6'd1, 32'd3, 26'd50, 1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL order_flag: got v=%b d=%h o=%b cnt=%0d",
                     m_tvalid, m_tdata, ooo, cnt_ooo);
        end
        step();
        n_tests++;
        if ({ooo, cnt_ooo} !== {1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL order_pulse: got o=%b cnt=%0d want 0 1", ooo, cnt_ooo);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        m_tready = 1'b0;
        drive(mk(200, 10), 4'hF, 32'd3);
        step();
        drive(mk(201, 11), 4'hF, 32'd3);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({m_tvalid, m_tdata, m_tuser, s_tready} !==
                {1'b1, 6'd1, 32'd3, 26'd200, 6'd10, 1'b0}) begin
                bad++;
            end
            step();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        m_tready = 1'b1;
        step();
        drive(mk(202, 12), 4'hF, 32'd3);
        n_tests++;
        if ({m_tvalid, m_tdata, m_tuser} !== {1'b1, 6'd1, 32'd3, 26'd201, 6'd11}) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b d=%h u=%h", m_tvalid, m_tdata, m_tuser);
        end
        step();
        idle();
        n_tests++;
        if ({m_tvalid, m_tdata, m_tuser} !== {1'b1, 6'd1, 32'd3, 26'd202, 6'd12}) begin
            n_fail++;
            $display("FAIL bp_next: got v=%b d=%h u=%h", m_tvalid, m_tdata, m_tuser);
        end
        step();
        n_tests++;
        if ({m_tvalid, cnt_drop, cnt_ooo} !== {1'b0, 32'd2, 32'd1}) begin
            n_fail++;
            $display("FAIL bp_after: got v=%b drop=%0d ooo=%0d want 0 2 1",
                     m_tvalid, cnt_drop, cnt_ooo);
        end
    endtask

    task automatic test_reset_mid();
        drive(mk(300, 7), 4'hF, 32'd3);
        step();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({m_tvalid, m_tdata, m_tuser, ooo, cnt_drop, cnt_ooo} !== 136'h0) begin
            n_fail++;
            $display("FAIL midrst_clear: got v=%b d=%h drop=%0d ooo=%0d",
                     m_tvalid, m_tdata, cnt_drop, cnt_ooo);
        end
        idle();
        step();
        rst = 1'b1;
        drive(mk(1, 0), 4'hF, 32'd1);
        step();
        idle();
        n_tests++;
        if ({m_tvalid, m_tdata, m_tuser, ooo} !==
            {1'b1, (64'd1 << 26) | 64'd1, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_first: got v=%b d=%h u=%h o=%b want d=%h",
                     m_tvalid, m_tdata, m_tuser, ooo, (64'd1 << 26) | 64'd1);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_epoch();
        test_order();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
